// File: rtl/red_pkg.sv
// Shared types, widths and the 4-bit carry-lookahead helper for the RED
// (nibble-reduction) sequencer.
package red_pkg;

    localparam int RED_DATA_W = 16;
    localparam int RED_NIB_W  = 4;
    localparam int RED_N_NIB  = RED_DATA_W / RED_NIB_W;
    // Holds the largest possible sum 2*N_NIB*(2^NIB_W-1) = 120 without overflow.
    localparam int RED_ACC_W  = RED_NIB_W + $clog2(2 * RED_N_NIB);
    localparam int RED_IDX_W  = $clog2(RED_N_NIB);
    localparam int RED_HI_W   = RED_ACC_W - RED_NIB_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } red_state_e;

    typedef logic [RED_DATA_W-1:0] red_data_t;
    typedef logic [RED_NIB_W-1:0]  red_nib_t;
    typedef logic [RED_ACC_W-1:0]  red_acc_t;
    typedef logic [RED_IDX_W-1:0]  red_idx_t;

    // 4-bit carry-lookahead adder. Returns {carry_out, sum}. All carries are
    // formed directly from generate/propagate terms, not rippled.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/red_seq_ctrl_if.sv
// Handshake and data bundle between the decode/hazard unit (master) and the
// RED sequencer in EX (slave).
interface red_seq_ctrl_if;
    import red_pkg::*;

    logic      start;
    logic      stall;
    red_data_t SrcData1;
    red_data_t SrcData2;
    logic      busy;
    logic      done;
    red_data_t DesData;

    modport master (
        output start, stall, SrcData1, SrcData2,
        input  busy, done, DesData
    );

    modport slave (
        input  start, stall, SrcData1, SrcData2,
        output busy, done, DesData
    );

endinterface

// File: rtl/red_nib_step.sv
// The single shared adder step: acc_next = acc + a_nib + b_nib.
// Low nibble goes through two chained 4-bit CLAs; the two carries they
// produce (0..2) are folded into the upper accumulator bits by a small
// incrementer.
module red_nib_step
    import red_pkg::*;
(
    input  red_acc_t acc,
    input  red_nib_t a_nib,
    input  red_nib_t b_nib,
    output red_acc_t acc_next
);

    logic [4:0]          w_sum_a;
    logic [4:0]          w_sum_ab;
    logic [1:0]          w_carry_cnt;
    logic [RED_HI_W-1:0] w_hi_next;

    // acc[3:0] + a_nib, then + b_nib.
    assign w_sum_a  = cla4(acc[RED_NIB_W-1:0], a_nib, 1'b0);
    assign w_sum_ab = cla4(w_sum_a[RED_NIB_W-1:0], b_nib, 1'b0);

    // Two carry bits summed into a 0..2 increment for the upper bits.
    assign w_carry_cnt = {w_sum_a[RED_NIB_W] & w_sum_ab[RED_NIB_W],
                          w_sum_a[RED_NIB_W] ^ w_sum_ab[RED_NIB_W]};

    assign w_hi_next = acc[RED_ACC_W-1:RED_NIB_W] + RED_HI_W'(w_carry_cnt);

    assign acc_next = {w_hi_next, w_sum_ab[RED_NIB_W-1:0]};

endmodule

// File: rtl/red_seq_ctrl.sv
// RED sequencer: sums all eight nibbles of two 16-bit operands over N_NIB
// RUN cycles using one shared nibble adder step. IDLE -> RUN -> DONE, with
// back-to-back acceptance from DONE and a global stall that freezes all state.
module red_seq_ctrl
    import red_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    red_seq_ctrl_if.slave  bus
);

    red_state_e r_state;
    red_idx_t   r_idx;
    red_acc_t   r_acc;
    red_data_t  r_op_a;
    red_data_t  r_op_b;
    logic       r_busy;
    logic       r_done;
    red_data_t  r_des_data;

    red_nib_t   w_a_nib;
    red_nib_t   w_b_nib;
    red_acc_t   w_acc_next;
    logic       w_last;

    // Current nibble of each captured operand, selected by the position counter.
    assign w_a_nib = r_op_a[RED_NIB_W*int'(r_idx) +: RED_NIB_W];
    assign w_b_nib = r_op_b[RED_NIB_W*int'(r_idx) +: RED_NIB_W];
    assign w_last  = (r_idx == RED_IDX_W'(RED_N_NIB - 1));

    red_nib_step u_step (
        .acc      (w_acc_next_src()),
        .a_nib    (w_a_nib),
        .b_nib    (w_b_nib),
        .acc_next (w_acc_next)
    );

    // Accumulator feeding the shared step is always the registered value.
    function automatic red_acc_t w_acc_next_src();
        return r_acc;
    endfunction

    // Sequencer FSM with its counter, operand, accumulator and result registers.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; blocking = would let later lines see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_acc      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_des_data <= '0;
        end else if (!bus.stall) begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_op_a  <= bus.SrcData1;
                        r_op_b  <= bus.SrcData2;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_des_data <= RED_DATA_W'(w_acc_next);
                        r_idx      <= '0;
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.DesData = r_des_data;

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Scoreboard bench for red_seq_ctrl: stimulus pushes expected results with
// their expected completion cycle; a negedge monitor pops one entry per
// completion (first DONE cycle after RUN) and compares.
module tb_red_seq_ctrl;
    import red_pkg::*;

    logic clk = 1'b0;
    logic rst;

    red_seq_ctrl_if bus ();

    red_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: one pop per completion, result and timing checked.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            check("busy_done_exclusive", 32'(bus.busy & bus.done), 0);
            if (bus.done && prev_busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(bus.DesData), 32'(e.data));
                    check("done_cycle", cyc, e.due);
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input logic [15:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
        bus.SrcData1 = a;
        bus.SrcData2 = b;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_op(exp, cyc + 4);
        wait_done();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.SrcData1 = '0;
        bus.SrcData2 = '0;
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_desdata", 32'(bus.DesData), 0);
        rst = 1'b0;
        tick();

        // Single op with detailed timing: busy for 4 cycles, done on the 5th.
        bus.SrcData1 = 16'h1234;
        bus.SrcData2 = 16'h0000;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_op(16'h000A, cyc + 4);
        for (int i = 0; i < 4; i++) begin
            check("busy_in_run", 32'(bus.busy), 1);
            tick();
        end
        check("done_after_run", 32'(bus.done), 1);
        tick();
        check("idle_done_low", 32'(bus.done), 0);
        check("idle_busy_low", 32'(bus.busy), 0);

        // Max value and a mixed pattern.
        run_op(16'hFFFF, 16'hFFFF, 16'h0078);
        run_op(16'h1234, 16'h4321, 16'h0014);

        // Back-to-back: start held high through RUN and DONE.
        bus.SrcData1 = 16'h1111;
        bus.SrcData2 = 16'h2222;
        bus.start    = 1'b1;
        tick();
        expect_op(16'h000C, cyc + 4);
        bus.SrcData1 = 16'h0F0F;
        bus.SrcData2 = 16'hF0F0;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_first_done", 32'(bus.done), 1);
        tick();
        expect_op(16'h003C, cyc + 4);
        check("b2b_rerun_busy", 32'(bus.busy), 1);
        check("b2b_desdata_held", 32'(bus.DesData), 32'h000C);
        bus.start = 1'b0;
        tick();
        bus.SrcData1 = 16'hFFFF;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        tick();
        check("b2b_no_extra_op", 32'(bus.busy), 0);

        // Stall for 3 cycles at RUN idx=2, then stall while in DONE.
        bus.SrcData1 = 16'h5678;
        bus.SrcData2 = 16'h0001;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_op(16'h001B, cyc + 4 + 3);
        tick();
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_run_busy", 32'(bus.busy), 1);
        end
        bus.stall = 1'b0;
        wait_done();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_done_hold", 32'(bus.done), 1);
        end
        check("stall_done_data", 32'(bus.DesData), 32'h001B);
        bus.stall = 1'b0;
        tick();
        check("stall_release_idle", 32'(bus.done), 0);

        // Reset mid-op at RUN idx=1: abandoned, no completion follows.
        bus.SrcData1 = 16'hAAAA;
        bus.SrcData2 = 16'h5555;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_desdata", 32'(bus.DesData), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_done", 32'(bus.done), 0);

        // Operand inputs change right after acceptance.
        bus.SrcData1 = 16'h1111;
        bus.SrcData2 = 16'h1111;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_op(16'h0008, cyc + 4);
        bus.SrcData1 = 16'hFFFF;
        bus.SrcData2 = 16'hFFFF;
        wait_done();
        tick();

        for (int i = 0; i < 3; i++) tick();
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
